// File: rtl/frost32_mem_arbiter_if.sv
// Requester/memory bundle for the Frost32 memory arbiter.
// slave: the arbiter side; master: requesters plus the memory model.
interface frost32_mem_arbiter_if #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata;
  logic [NUM_CH-1:0]            ch_access_type;
  logic [NUM_CH*2-1:0]          ch_access_size;
  logic [NUM_CH-1:0]            ch_done;
  logic                         ch_err;
  logic [DATA_WIDTH-1:0]        ch_rdata;
  logic                         mem_req;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]        mem_data_out;
  logic                         mem_access_type;
  logic [1:0]                   mem_access_size;
  logic [DATA_WIDTH-1:0]        mem_data_in;
  logic                         mem_wait;

  modport slave (
    input  ch_req, ch_addr, ch_wdata, ch_access_type, ch_access_size,
    input  mem_data_in, mem_wait,
    output ch_done, ch_err, ch_rdata,
    output mem_req, mem_addr, mem_data_out, mem_access_type, mem_access_size
  );

  modport master (
    output ch_req, ch_addr, ch_wdata, ch_access_type, ch_access_size,
    output mem_data_in, mem_wait,
    input  ch_done, ch_err, ch_rdata,
    input  mem_req, mem_addr, mem_data_out, mem_access_type, mem_access_size
  );
endinterface

// File: rtl/frost32_mem_arbiter.sv
// Round-robin N-channel arbiter onto a single wait-for-mem memory port.
// One transaction in flight; misaligned or bad-size requests complete with ch_err.
module frost32_mem_arbiter #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  frost32_mem_arbiter_if.slave bus
);
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_WIDTH-1:0] WordMask = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
  localparam logic [ADDR_WIDTH-1:0] HalfMask = ADDR_WIDTH'(DATA_WIDTH / 16 - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q;
  logic [ChW-1:0]  rr_q;
  logic [ChW-1:0]  grant_q;

  logic [NUM_CH-1:0]     eligible;
  logic                  found;
  logic [ChW-1:0]        pick;
  logic [ChW-1:0]        rr_next;
  int unsigned           idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_type;
  logic [1:0]            sel_size;
  logic                  sel_err;

  always_comb begin
    eligible = bus.ch_req & ~bus.ch_done;
    found    = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_q) + i) % NUM_CH;
      if (!found && eligible[ChW'(idx)]) begin
        found = 1'b1;
        pick  = ChW'(idx);
      end
    end
    rr_next   = (32'(pick) + 1 == NUM_CH) ? '0 : ChW'(32'(pick) + 1);
    sel_addr  = bus.ch_addr[32'(pick) * ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = bus.ch_wdata[32'(pick) * DATA_WIDTH +: DATA_WIDTH];
    sel_type  = bus.ch_access_type[pick];
    sel_size  = bus.ch_access_size[32'(pick) * 2 +: 2];
    sel_err   = (sel_size == 2'd3) ||
                (sel_size == 2'd0 && |(sel_addr & WordMask)) ||
                (sel_size == 2'd1 && |(sel_addr & HalfMask));
  end

  // The mem_* output registers double as the latched request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= StIdle;
      rr_q                <= '0;
      grant_q             <= '0;
      bus.ch_done         <= '0;
      bus.ch_err          <= 1'b0;
      bus.ch_rdata        <= '0;
      bus.mem_req         <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_data_out    <= '0;
      bus.mem_access_type <= 1'b0;
      bus.mem_access_size <= 2'd0;
    end else begin
      bus.mem_req  <= 1'b0;
      bus.ch_done  <= '0;
      bus.ch_err   <= 1'b0;
      bus.ch_rdata <= '0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q <= pick;
            rr_q    <= rr_next;
            if (sel_err) begin
              state_q     <= StDone;
              bus.ch_done <= NUM_CH'(1) << pick;
              bus.ch_err  <= 1'b1;
            end else begin
              state_q             <= StIssue;
              bus.mem_req         <= 1'b1;
              bus.mem_addr        <= sel_addr;
              bus.mem_data_out    <= sel_wdata;
              bus.mem_access_type <= sel_type;
              bus.mem_access_size <= sel_size;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          // mem_wait seen during ISSUE is deliberately ignored.
          if (!bus.mem_wait) begin
            state_q             <= StDone;
            bus.ch_done         <= NUM_CH'(1) << grant_q;
            bus.ch_rdata        <= bus.mem_access_type ? '0 : bus.mem_data_in;
            bus.mem_addr        <= '0;
            bus.mem_data_out    <= '0;
            bus.mem_access_type <= 1'b0;
            bus.mem_access_size <= 2'd0;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
